// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the MEM-stage load/store unit.
// The optional misalignment trap is selected with the LSU_MISALIGN_TRAP_EN macro.
package lsu_pkg;

    // RISC-V load/store width encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Lane geometry of the 32-bit data word
    localparam int WORD_W    = 32;
    localparam int HALF_W    = 16;
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = WORD_W / LANE_W;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: request/response handshake plus the data-memory
// enable/address/data bus. The LSU uses the slave modport; the pipeline
// and memory side use the master modport.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              mem_r_enable;
    logic              mem_w_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_re_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_re_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_r_enable, mem_w_enable, mem_address, mem_wr_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_re_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_r_enable, mem_w_enable, mem_address, mem_wr_data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane logic. Selects and extends the load
// lane, merges SB/SH data into the read word, and flags illegal accesses.
// LSU_MISALIGN_TRAP_EN defined: misaligned H/W accesses are errors.
// LSU_MISALIGN_TRAP_EN undefined: misaligned H/W are forced to alignment.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic              we,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] rdata,
    input  logic [HALF_W-1:0] st_data,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged,
    output logic              err
);
    logic                 illegal;
    logic                 misalign;
    logic [1:0]           off;
    logic [LANE_W-1:0]    ld_byte;
    logic [HALF_W-1:0]    ld_half;
    logic [WORD_W-1:0]    wrep;
    logic [NUM_LANES-1:0] bmask;

    // Illegal encodings, including unsigned widths used as stores
    always_comb begin
        illegal = 1'b1;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = we;
            default:          illegal = 1'b1;
        endcase
    end

    // Effective lane offset; misaligned low bits either trap or are dropped
    always_comb begin
        misalign = 1'b0;
        off      = addr_lo;
        case (funct3)
            F3_H, F3_HU: begin
                off = {addr_lo[1], 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
                misalign = addr_lo[0];
`endif
            end
            F3_W: begin
                off = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign = |addr_lo;
`endif
            end
            default: ;
        endcase
    end

    assign err     = illegal | misalign;
    assign ld_byte = rdata[{off, 3'b000} +: LANE_W];
    assign ld_half = rdata[{off[1], 4'b0000} +: HALF_W];

    // Load lane extension: B/H sign-extend, BU/HU zero-extend
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{(WORD_W-LANE_W){ld_byte[LANE_W-1]}}, ld_byte};
            F3_BU:   load_data = {{(WORD_W-LANE_W){1'b0}}, ld_byte};
            F3_H:    load_data = {{(WORD_W-HALF_W){ld_half[HALF_W-1]}}, ld_half};
            F3_HU:   load_data = {{(WORD_W-HALF_W){1'b0}}, ld_half};
            F3_W:    load_data = rdata;
            default: load_data = '0;
        endcase
    end

    // Store data replicated across lanes; the mask picks which lanes take it
    always_comb begin
        wrep  = (funct3 == F3_B) ? {NUM_LANES{st_data[LANE_W-1:0]}} : {2{st_data}};
        bmask = '0;
        case (funct3)
            F3_B:    bmask = NUM_LANES'(1) << off;
            F3_H:    bmask = NUM_LANES'(3) << off;
            default: bmask = '0;
        endcase
        merged = rdata;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bmask[i]) merged[i*LANE_W +: LANE_W] = wrep[i*LANE_W +: LANE_W];
        end
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store unit driving a word-wide data memory.
// Loads and SW complete in one cycle; SB/SH read-modify-write over two.
// Optional LSU_MISALIGN_TRAP_EN reports misaligned H/W as errors.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_ctrl_if.slave     bus
);
    state_e            state, state_nxt;
    logic              accept;
    logic              is_word;
    logic              lane_err;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic              r_en, w_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;

    lsu_lane_align u_align (
        .funct3    (bus.req_funct3),
        .we        (bus.req_we),
        .addr_lo   (bus.req_addr[1:0]),
        .rdata     (bus.mem_re_data),
        .st_data   (bus.req_wdata[HALF_W-1:0]),
        .load_data (load_data),
        .merged    (merged),
        .err       (lane_err)
    );

    assign bus.req_ready = rst_n && (state == ST_IDLE);
    assign accept        = bus.req_ready && bus.req_valid;
    assign is_word       = (bus.req_funct3 == F3_W);
    assign word_addr     = {bus.req_addr[ADDR_W-1:2], 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and memory strobes; everything idles low while in reset
    always_comb begin
        state_nxt = state;
        r_en      = 1'b0;
        w_en      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (accept && !lane_err) begin
                        m_addr = word_addr;
                        if (!bus.req_we) begin
                            r_en = 1'b1;
                        end else if (is_word) begin
                            w_en    = 1'b1;
                            m_wdata = bus.req_wdata;
                        end else begin
                            r_en      = 1'b1;
                            state_nxt = ST_RMW_WR;
                        end
                    end
                end
                ST_RMW_WR: begin
                    w_en      = 1'b1;
                    m_addr    = buf_addr;
                    m_wdata   = buf_data;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Response register and RMW buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            buf_addr     <= '0;
            buf_data     <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            if (state == ST_RMW_WR) begin
                resp_valid_q <= 1'b1;
            end else if (accept) begin
                if (lane_err) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                end else if (!bus.req_we) begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_data;
                end else if (is_word) begin
                    resp_valid_q <= 1'b1;
                end else begin
                    buf_addr <= word_addr;
                    buf_data <= merged;
                end
            end
        end
    end

    assign bus.mem_r_enable = r_en;
    assign bus.mem_w_enable = w_en;
    assign bus.mem_address  = m_addr;
    assign bus.mem_wr_data  = m_wdata;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_err     = resp_err_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl with a 32-word memory
// initialised to dmem[i] = i. Expected responses carry their due cycle.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] dmem [32];

    lsu_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on posedge
    initial for (int i = 0; i < 32; i++) dmem[i] = i;
    always @(posedge clk) if (bus.mem_w_enable === 1'b1) dmem[bus.mem_address[6:2]] <= bus.mem_wr_data;
    assign bus.mem_re_data = dmem[bus.mem_address[6:2]];

    // Response monitor
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            exp_t e;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp cyc=%0d rdata=%h err=%b", cyc, bus.resp_rdata, bus.resp_err);
            end else begin
                e = sbq.pop_front();
                if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err || cyc != e.due) begin
                    errors++;
                    $display("FAIL resp got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                             bus.resp_rdata, bus.resp_err, cyc, e.rdata, e.err, e.due);
                end
            end
        end
    end

    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic expect_resp(input logic err, input logic [31:0] rdata, input int lat);
        sbq.push_back('{err, rdata, cyc + lat});
    endtask

    task automatic test_reset();
        @(negedge clk);
        req(1'b1, F3_W, 32'h10, 32'h1234_5678);
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_r_enable !== 1'b0 || bus.mem_w_enable !== 1'b0 ||
            bus.mem_address !== 32'h0 || bus.mem_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b re=%b we=%b a=%h d=%h want all 0",
                     bus.req_ready, bus.mem_r_enable, bus.mem_w_enable, bus.mem_address, bus.mem_wr_data);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp got v=%b d=%h e=%b want 0 0 0", bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        idle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_sw_lw();
        @(negedge clk);
        req(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
        expect_resp(1'b0, 32'h0, 1);
        #1;
        checks++;
        if (bus.mem_w_enable !== 1'b1 || bus.mem_r_enable !== 1'b0 ||
            bus.mem_address !== 32'h10 || bus.mem_wr_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_bus got we=%b re=%b a=%h d=%h want 1 0 00000010 deadbeef",
                     bus.mem_w_enable, bus.mem_r_enable, bus.mem_address, bus.mem_wr_data);
        end
        @(negedge clk);
        req(1'b0, F3_W, 32'h10, 32'h0);
        expect_resp(1'b0, 32'hDEAD_BEEF, 1);
        #1;
        checks++;
        if (bus.mem_r_enable !== 1'b1 || bus.mem_w_enable !== 1'b0) begin
            errors++;
            $display("FAIL lw_bus got re=%b we=%b want 1 0", bus.mem_r_enable, bus.mem_w_enable);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_lanes();
        @(negedge clk); req(1'b0, F3_B,  32'h13, 32'h0); expect_resp(1'b0, 32'hFFFF_FFDE, 1);
        @(negedge clk); req(1'b0, F3_BU, 32'h13, 32'h0); expect_resp(1'b0, 32'h0000_00DE, 1);
        @(negedge clk); req(1'b0, F3_H,  32'h12, 32'h0); expect_resp(1'b0, 32'hFFFF_DEAD, 1);
        @(negedge clk); idle();
    endtask

    task automatic test_sb_rmw();
        @(negedge clk);
        req(1'b1, F3_B, 32'h11, 32'h0000_0055);
        expect_resp(1'b0, 32'h0, 2);
        #1;
        checks++;
        if (bus.mem_r_enable !== 1'b1 || bus.mem_w_enable !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_read got re=%b we=%b rdy=%b want 1 0 1", bus.mem_r_enable, bus.mem_w_enable, bus.req_ready);
        end
        @(negedge clk);
        // next request presented during RMW_WR and held until accepted
        req(1'b0, F3_HU, 32'h10, 32'h0);
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_w_enable !== 1'b1 || bus.mem_r_enable !== 1'b0 ||
            bus.mem_address !== 32'h10 || bus.mem_wr_data !== 32'hDEAD_55EF) begin
            errors++;
            $display("FAIL sb_rmw got rdy=%b we=%b re=%b a=%h d=%h want 0 1 0 00000010 dead55ef",
                     bus.req_ready, bus.mem_w_enable, bus.mem_r_enable, bus.mem_address, bus.mem_wr_data);
        end
        @(negedge clk);
        expect_resp(1'b0, 32'h0000_55EF, 1);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || dmem[4] !== 32'hDEAD_55EF) begin
            errors++;
            $display("FAIL sb_done got rdy=%b mem4=%h want 1 dead55ef", bus.req_ready, dmem[4]);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_errors();
        @(negedge clk);
        req(1'b0, F3_W, 32'h06, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        expect_resp(1'b1, 32'h0, 1);
        #1;
        checks++;
        if (bus.mem_r_enable !== 1'b0 || bus.mem_w_enable !== 1'b0) begin
            errors++;
            $display("FAIL misalign_enables got re=%b we=%b want 0 0", bus.mem_r_enable, bus.mem_w_enable);
        end
`else
        expect_resp(1'b0, 32'h0000_0001, 1);
        #1;
        checks++;
        if (bus.mem_r_enable !== 1'b1 || bus.mem_address !== 32'h04) begin
            errors++;
            $display("FAIL misalign_aligned got re=%b a=%h want 1 00000004", bus.mem_r_enable, bus.mem_address);
        end
`endif
        @(negedge clk);
        req(1'b0, 3'b011, 32'h0, 32'h0);
        expect_resp(1'b1, 32'h0, 1);
        #1;
        checks++;
        if (bus.mem_r_enable !== 1'b0 || bus.mem_w_enable !== 1'b0) begin
            errors++;
            $display("FAIL illegal_f3 got re=%b we=%b want 0 0", bus.mem_r_enable, bus.mem_w_enable);
        end
        @(negedge clk);
        req(1'b1, F3_BU, 32'h0, 32'hFF);
        expect_resp(1'b1, 32'h0, 1);
        #1;
        checks++;
        if (bus.mem_r_enable !== 1'b0 || bus.mem_w_enable !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_bu got re=%b we=%b rdy=%b want 0 0 1", bus.mem_r_enable, bus.mem_w_enable, bus.req_ready);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_rmw();
        @(negedge clk);
        req(1'b1, F3_H, 32'h20, 32'h0000_ABCD);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_w_enable !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw_write got we=%b want 0", bus.mem_w_enable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || dmem[8] !== 32'h0000_0008) begin
            errors++;
            $display("FAIL rst_rmw_after got rdy=%b mem8=%h want 1 00000008", bus.req_ready, dmem[8]);
        end
        @(negedge clk);
        req(1'b0, F3_W, 32'h20, 32'h0);
        expect_resp(1'b0, 32'h0000_0008, 1);
        @(negedge clk);
        idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); req(1'b0, F3_W, 32'h00, 32'h0); expect_resp(1'b0, 32'h0, 1);
        @(negedge clk); req(1'b0, F3_W, 32'h04, 32'h0); expect_resp(1'b0, 32'h1, 1);
        @(negedge clk); req(1'b0, F3_W, 32'h08, 32'h0); expect_resp(1'b0, 32'h2, 1);
        @(negedge clk); idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sbq.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        test_reset();
        test_sw_lw();
        test_lanes();
        test_sb_rmw();
        test_errors();
        test_reset_rmw();
        test_back_to_back();
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
